ledger_arbiter: RTL
===================

LEDGER_ARBITER -- requirements
Module: ledger_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of ATM requester ports.
REQ-002 SHALL have parameter NACC, default 10, meaning number of accounts in the balance store.
REQ-003 SHALL have parameter INIT_BAL, default 500, meaning the per-account balance loaded at reset.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  NREQ  per-requester request level; held high until that requester sees done with its grant bit set.
REQ-007 op  input  2*NREQ  per-requester opcode: 0 BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 TRANSFER.
REQ-008 src_idx  input  4*NREQ  per-requester source account index.
REQ-009 dst_idx  input  4*NREQ  per-requester destination index; used only by TRANSFER.
REQ-010 amount  input  16*NREQ  per-requester unsigned amount.
REQ-011 grant  output  NREQ  one-hot; identifies the requester being served.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 error  output  1  valid with done; 1 means the operation was rejected.
REQ-015 balance  output  16  valid with done; source-account balance after the operation.

Function
REQ-016 SHALL own a NACC x 16-bit balance store, the only path by which requesters read or modify balances.
REQ-017 FSM states SHALL be IDLE, READ, EXEC, WRITE, RESP, advancing one state per cycle with no stalls.
REQ-018 In IDLE with any req high: pick winner round-robin, starting at the requester after the last one served; latch its op/src/dst/amount; set grant; go to READ.
REQ-019 In IDLE with no req high: stay in IDLE; grant stays 0.
REQ-020 READ SHALL load the src and dst balances into internal registers.
REQ-021 EXEC SHALL compute the new balances and the error flag.
REQ-022 WRITE SHALL commit the new balances only when error=0; BALANCE never writes.
REQ-023 RESP SHALL pulse done for one cycle with error and balance valid; grant stays set.
REQ-024 After RESP: clear grant, advance the round-robin pointer, and return to IDLE.
REQ-025 Latency: winner latched at edge N; done high in the cycle after edge N+3; one operation per 5 cycles max.
REQ-026 Request fields sampled after latching SHALL be ignored; req dropping mid-operation does not abort it.
REQ-027 A req still high in the IDLE cycle after its done SHALL be treated as a new request, at lowest round-robin priority.
REQ-028 Error conditions:
- src_idx >= NACC
- TRANSFER with dst_idx >= NACC or dst_idx == src_idx
- WITHDRAW or TRANSFER with amount > src balance
- DEPOSIT with src + amount > 65535
- TRANSFER with dst + amount > 65535
REQ-029 Boundary: amount equal to balance is legal and yields 0; amount 0 is legal for all ops.
REQ-030 On error, balance SHALL return the unchanged src balance, or 0 if src_idx is out of range.
REQ-031 TRANSFER SHALL update both accounts in the same WRITE cycle; no partial commit.
REQ-032 Arithmetic SHALL be unsigned, using 17-bit intermediates for overflow detection.

Reset
REQ-033 On rst: state IDLE; grant, busy, done, error = 0; balance = 0; round-robin pointer selects requester 0 first; all accounts = INIT_BAL.
REQ-034 rst asserted before the WRITE edge SHALL discard the in-flight operation with no store change and no done pulse.

Structure
REQ-035 Shared package atm_pkg SHALL hold the opcode constants, the FSM state encoding, NACC_MAX and INIT_BAL.
REQ-036 Round-robin selection SHALL be a sub-module rr_picker (inputs req and pointer; output one-hot winner).

Verification
REQ-037 Reset, then req0 BALANCE src=3 -> done 4 cycles after latch, balance=500, error=0, grant=0001.
REQ-038 req0 WITHDRAW src=1 amt=500 -> balance=0, error=0; repeat amt=1 -> error=1, balance=0.
REQ-039 req2 TRANSFER src=4 dst=7 amt=120 -> balance=380; then BALANCE dst=7 -> 620; TRANSFER src=dst=4 -> error=1.
REQ-040 All four req high simultaneously, each held through its own done -> grants in order 0,1,2,3, 20 cycles total, each with one done.
REQ-041 DEPOSIT src=5 amt=65100 -> error=1, balance=500; amt=65035 -> balance=65535, error=0.
REQ-042 rst pulse during EXEC of WITHDRAW src=2 amt=100 -> no done; then BALANCE src=2 -> 500.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared opcode, FSM encoding and sizing constants for the ATM ledger arbiter.
package atm_pkg;

  typedef enum logic [1:0] {
    OpBalance  = 2'd0,
    OpWithdraw = 2'd1,
    OpDeposit  = 2'd2,
    OpTransfer = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StExec,
    StWrite,
    StResp
  } state_e;

  localparam int unsigned NACC_MAX = 16;
  localparam int unsigned INIT_BAL = 500;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping, as a one-hot vector.
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NREQ-1:0] winner
);

  localparam int unsigned IdxW = $clog2(2 * NREQ);

  logic [IdxW-1:0] pos;
  logic            found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = IdxW'(ptr) + IdxW'(i);
      if (pos >= IdxW'(NREQ)) begin
        pos = pos - IdxW'(NREQ);
      end
      if (!found && req[PtrW'(pos)]) begin
        found               = 1'b1;
        winner[PtrW'(pos)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ledger_arbiter.sv
// Round-robin arbiter serialising ATM requests onto a shared account balance store.
module ledger_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned NACC     = 10,
  parameter int unsigned INIT_BAL = atm_pkg::INIT_BAL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  op,
  input  logic [4*NREQ-1:0]  src_idx,
  input  logic [4*NREQ-1:0]  dst_idx,
  input  logic [16*NREQ-1:0] amount,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [15:0]        balance
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  atm_pkg::state_e state_q, state_d;
  atm_pkg::op_e    op_q, op_d;
  logic [NREQ-1:0] grant_q, grant_d, winner;
  logic [PtrW-1:0] ptr_q, ptr_d, grant_idx;
  logic [3:0]      src_q, src_d, dst_q, dst_d;
  logic [15:0]     amt_q, amt_d;
  logic [15:0]     src_bal_q, src_bal_d, dst_bal_q, dst_bal_d;
  logic            src_ok_q, src_ok_d, dst_ok_q, dst_ok_d;
  logic [15:0]     new_src_q, new_src_d, new_dst_q, new_dst_d;
  logic            err_q, err_d;
  logic [15:0]     resp_q, resp_d;
  logic [15:0]     mem_q [NACC];
  logic [15:0]     mem_d [NACC];

  logic [1:0]  sel_op;
  logic [3:0]  sel_src, sel_dst;
  logic [15:0] sel_amt;
  logic [15:0] src_rd, dst_rd;
  logic        src_hit, dst_hit;
  logic [16:0] sum_src, sum_dst;
  logic        short_src;

  rr_picker #(
    .NREQ(NREQ),
    .PtrW(PtrW)
  ) u_rr_picker (
    .req   (req),
    .ptr   (ptr_q),
    .winner(winner)
  );

  always_comb begin
    sel_op    = '0;
    sel_src   = '0;
    sel_dst   = '0;
    sel_amt   = '0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        sel_op  = op[2*i +: 2];
        sel_src = src_idx[4*i +: 4];
        sel_dst = dst_idx[4*i +: 4];
        sel_amt = amount[16*i +: 16];
      end
      if (grant_q[i]) begin
        grant_idx = PtrW'(i);
      end
    end
  end

  // Out-of-range indices read as 0 and clear the hit flag.
  always_comb begin
    src_rd  = '0;
    dst_rd  = '0;
    src_hit = 1'b0;
    dst_hit = 1'b0;
    for (int a = 0; a < NACC; a++) begin
      if (src_q == 4'(a)) begin
        src_hit = 1'b1;
        src_rd  = mem_q[a];
      end
      if (dst_q == 4'(a)) begin
        dst_hit = 1'b1;
        dst_rd  = mem_q[a];
      end
    end
  end

  assign sum_src   = {1'b0, src_bal_q} + {1'b0, amt_q};
  assign sum_dst   = {1'b0, dst_bal_q} + {1'b0, amt_q};
  assign short_src = amt_q > src_bal_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    src_d     = src_q;
    dst_d     = dst_q;
    amt_d     = amt_q;
    src_bal_d = src_bal_q;
    dst_bal_d = dst_bal_q;
    src_ok_d  = src_ok_q;
    dst_ok_d  = dst_ok_q;
    new_src_d = new_src_q;
    new_dst_d = new_dst_q;
    err_d     = err_q;
    resp_d    = resp_q;
    mem_d     = mem_q;
    case (state_q)
      atm_pkg::StIdle: begin
        if (|req) begin
          grant_d = winner;
          op_d    = atm_pkg::op_e'(sel_op);
          src_d   = sel_src;
          dst_d   = sel_dst;
          amt_d   = sel_amt;
          state_d = atm_pkg::StRead;
        end
      end
      atm_pkg::StRead: begin
        src_bal_d = src_rd;
        dst_bal_d = dst_rd;
        src_ok_d  = src_hit;
        dst_ok_d  = dst_hit;
        state_d   = atm_pkg::StExec;
      end
      atm_pkg::StExec: begin
        new_src_d = src_bal_q;
        new_dst_d = dst_bal_q;
        err_d     = ~src_ok_q;
        case (op_q)
          atm_pkg::OpWithdraw: begin
            err_d     = ~src_ok_q | short_src;
            new_src_d = src_bal_q - amt_q;
          end
          atm_pkg::OpDeposit: begin
            err_d     = ~src_ok_q | sum_src[16];
            new_src_d = sum_src[15:0];
          end
          atm_pkg::OpTransfer: begin
            err_d     = ~src_ok_q | ~dst_ok_q | (dst_q == src_q) | short_src | sum_dst[16];
            new_src_d = src_bal_q - amt_q;
            new_dst_d = sum_dst[15:0];
          end
          default: ;
        endcase
        resp_d  = err_d ? src_bal_q : new_src_d;
        state_d = atm_pkg::StWrite;
      end
      atm_pkg::StWrite: begin
        // An error-free transfer guarantees distinct src/dst, so both writes land together.
        if (!err_q && op_q != atm_pkg::OpBalance) begin
          for (int a = 0; a < NACC; a++) begin
            if (src_q == 4'(a)) begin
              mem_d[a] = new_src_q;
            end
            if (op_q == atm_pkg::OpTransfer && dst_q == 4'(a)) begin
              mem_d[a] = new_dst_q;
            end
          end
        end
        state_d = atm_pkg::StResp;
      end
      atm_pkg::StResp: begin
        grant_d = '0;
        ptr_d   = (grant_idx == PtrW'(NREQ - 1)) ? '0 : grant_idx + PtrW'(1);
        state_d = atm_pkg::StIdle;
      end
      default: begin
        state_d = atm_pkg::StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= atm_pkg::StIdle;
      op_q      <= atm_pkg::OpBalance;
      grant_q   <= '0;
      ptr_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      amt_q     <= '0;
      src_bal_q <= '0;
      dst_bal_q <= '0;
      src_ok_q  <= 1'b0;
      dst_ok_q  <= 1'b0;
      new_src_q <= '0;
      new_dst_q <= '0;
      err_q     <= 1'b0;
      resp_q    <= '0;
      for (int a = 0; a < NACC; a++) begin
        mem_q[a] <= 16'(INIT_BAL);
      end
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      amt_q     <= amt_d;
      src_bal_q <= src_bal_d;
      dst_bal_q <= dst_bal_d;
      src_ok_q  <= src_ok_d;
      dst_ok_q  <= dst_ok_d;
      new_src_q <= new_src_d;
      new_dst_q <= new_dst_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      mem_q     <= mem_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != atm_pkg::StIdle);
  assign done    = (state_q == atm_pkg::StResp);
  assign error   = done & err_q;
  assign balance = done ? resp_q : '0;

endmodule
